// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the RV32I multi-cycle sequencer: opcode constants,
//   ALU operation codes, immediate-type and write-back-source encodings, FSM
//   state encoding, the registered control bundle and an ALU-op helper.
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;   // addi x0,x0,0
    localparam int          WAIT_W   = 5;                // wait-counter width

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_SB = 3'd2,
        IMM_UJ = 3'd3,
        IMM_U  = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,   // PC+4, or PC+imm when pc_offset is set
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef struct packed {
        alu_op_e  alu_op;
        imm_sel_e imm_sel;
        wb_sel_e  mem_to_reg;
        logic     alu_src_b;
        logic     jump;
        logic     branch;
        logic     inv_branch;
        logic     pc_offset;
        logic     reg_write;   // already qualified with rd != x0
        logic     mem_rd;
        logic     mem_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, imm_sel: IMM_I, mem_to_reg: WB_ALU,
                                   alu_src_b: 1'b0, jump: 1'b0, branch: 1'b0,
                                   inv_branch: 1'b0, pc_offset: 1'b0, reg_write: 1'b0,
                                   mem_rd: 1'b0, mem_wr: 1'b0};

    // funct7 bit 5 only selects SUB for register-register ops; SRA/SRAI use it in both.
    function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3,
                                                  input logic       funct7_b5,
                                                  input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Instruction- and data-memory handshake bundle.
//   master : sequencer side (drives imem_req, dmem_req, dmem_we)
//   slave  : memory side    (drives imem_ack, imem_rdata, dmem_ack)
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we,
                    input  imem_ack, imem_rdata, dmem_ack);
    modport slave  (input  imem_req, dmem_req, dmem_we,
                    output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/multicycle_decode.sv
// ----------------------------------------------------------------------------
// multicycle_decode
//   Pure combinational RV32I decoder: instruction fields -> control bundle
//   plus an illegal-instruction flag.
//   opcode, funct3, funct7_b5, rd_nz : fields of the latched IR
//   ctrl                             : decoded control bundle
//   illegal                          : unsupported opcode / branch funct3
// ----------------------------------------------------------------------------
module multicycle_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       rd_nz,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.alu_op    = alu_op_from_funct(funct3, funct7_b5, 1'b1);
                ctrl.reg_write = rd_nz;
            end
            OP_I: begin
                ctrl.alu_op    = alu_op_from_funct(funct3, funct7_b5, 1'b0);
                ctrl.alu_src_b = 1'b1;
                ctrl.reg_write = rd_nz;
            end
            OP_LOAD: begin
                ctrl.alu_src_b  = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
                ctrl.mem_rd     = 1'b1;
                ctrl.reg_write  = rd_nz;
            end
            OP_STORE: begin
                ctrl.imm_sel   = IMM_S;
                ctrl.alu_src_b = 1'b1;
                ctrl.mem_wr    = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.imm_sel    = IMM_SB;
                ctrl.branch     = 1'b1;
                ctrl.inv_branch = funct3[0];   // bne/bge/bgeu invert the compare result
                case (funct3[2:1])
                    2'b00:   ctrl.alu_op = ALU_SUB;
                    2'b10:   ctrl.alu_op = ALU_SLT;
                    2'b11:   ctrl.alu_op = ALU_SLTU;
                    default: illegal     = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl.imm_sel    = IMM_UJ;
                ctrl.jump       = 1'b1;
                ctrl.mem_to_reg = WB_PC;
                ctrl.reg_write  = rd_nz;
            end
            OP_JALR: begin
                ctrl.alu_src_b  = 1'b1;        // target = rs1 + imm through the ALU
                ctrl.jump       = 1'b1;
                ctrl.mem_to_reg = WB_PC;
                ctrl.reg_write  = rd_nz;
            end
            OP_LUI: begin
                ctrl.imm_sel    = IMM_U;
                ctrl.mem_to_reg = WB_IMM;
                ctrl.reg_write  = rd_nz;
            end
            OP_AUIPC: begin
                ctrl.imm_sel    = IMM_U;
                ctrl.mem_to_reg = WB_PC;
                ctrl.pc_offset  = 1'b1;        // write PC+imm instead of PC+4
                ctrl.reg_write  = rd_nz;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle RV32I sequencer: IDLE->FETCH->DECODE->EXEC->[MEM]->WB->FETCH,
//   HALT on memory timeout or illegal instruction (left only by reset).
//   clk, rst        : clock, asynchronous active-low reset
//   mem             : instruction/data memory handshakes (master modport)
//   inst_field      : latched IR
//   ALU_Control ... PCOffset : decoded datapath controls, registered in DECODE
//   RegWrite, pc_we : one-cycle write strobes in WB
//   pc_reset_val    : RESET_PC passthrough
//   busy, bus_err   : not-IDLE flag, sticky error flag
//   Optional (MULTICYCLE_PERF_CNT_EN): cycle_cnt, instret_cnt 64-bit counters.
//   All outputs come straight from flops.
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_TMO  = 16
)(
    input  logic        clk,
    input  logic        rst,
    multicycle_ctrl_if.master mem,
    output logic [31:0] inst_field,
    output logic [3:0]  ALU_Control,
    output logic [2:0]  ImmSel,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrc_B,
    output logic        Jump,
    output logic        Branch,
    output logic        InverseBranch,
    output logic        PCOffset,
    output logic        RegWrite,
    output logic        pc_we,
    output logic [31:0] pc_reset_val,
    output logic        busy,
    output logic        bus_err
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    // Last wait count at which an ack is still accepted.
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TMO - 1);

    state_e              state_q;
    logic [31:0]         ir_q;
    ctrl_t               ctrl_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                imem_req_q, dmem_req_q, dmem_we_q;
    logic                reg_write_q, pc_we_q, busy_q, bus_err_q;

    ctrl_t               ctrl_d;
    logic                illegal_d;

    multicycle_decode u_decode (
        .opcode    (ir_q[6:0]),
        .funct3    (ir_q[14:12]),
        .funct7_b5 (ir_q[30]),
        .rd_nz     (|ir_q[11:7]),
        .ctrl      (ctrl_d),
        .illegal   (illegal_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ir_q        <= NOP_INSN;
            ctrl_q      <= CTRL_NOP;
            wait_q      <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_write_q <= 1'b0;
            pc_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every flop samples pre-edge values of the others.
            reg_write_q <= 1'b0;
            pc_we_q     <= 1'b0;
            busy_q      <= 1'b1;   // IDLE is only ever entered through reset
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                    wait_q     <= '0;
                end
                S_FETCH: begin
                    if (mem.imem_ack) begin          // ack beats the terminal count
                        ir_q       <= mem.imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (wait_q == TMO_LAST) begin
                        imem_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (illegal_d) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        ctrl_q  <= ctrl_d;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ctrl_q.mem_rd || ctrl_q.mem_wr) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= ctrl_q.mem_wr;
                        wait_q     <= '0;
                        state_q    <= S_MEM;
                    end else begin
                        reg_write_q <= ctrl_q.reg_write;
                        pc_we_q     <= 1'b1;
                        state_q     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        dmem_req_q  <= 1'b0;
                        dmem_we_q   <= 1'b0;
                        reg_write_q <= ctrl_q.reg_write;
                        pc_we_q     <= 1'b1;
                        state_q     <= S_WB;
                    end else if (wait_q == TMO_LAST) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB: begin
                    imem_req_q <= 1'b1;
                    wait_q     <= '0;
                    state_q    <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: begin                        // unreachable encoding: fail safe
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    bus_err_q  <= 1'b1;
                    state_q    <= S_HALT;
                end
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) cycle_cnt_q   <= cycle_cnt_q + 64'd1;
            if (state_q == S_WB)   instret_cnt_q <= instret_cnt_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

    assign mem.imem_req  = imem_req_q;
    assign mem.dmem_req  = dmem_req_q;
    assign mem.dmem_we   = dmem_we_q;

    assign inst_field    = ir_q;
    assign ALU_Control   = ctrl_q.alu_op;
    assign ImmSel        = ctrl_q.imm_sel;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUSrc_B      = ctrl_q.alu_src_b;
    assign Jump          = ctrl_q.jump;
    assign Branch        = ctrl_q.branch;
    assign InverseBranch = ctrl_q.inv_branch;
    assign PCOffset      = ctrl_q.pc_offset;
    assign RegWrite      = reg_write_q;
    assign pc_we         = pc_we_q;
    assign pc_reset_val  = RESET_PC;
    assign busy          = busy_q;
    assign bus_err       = bus_err_q;

endmodule
